seg_mask_pipe: RTL
==================

// Module: seg_mask_pipe
// PURPOSE
//  Parametrised, pipelined segment-mask unit for the GNG datapath. Accepts a SEG_W-bit segment plus its
//  bit position inside a WIN_LEN-bit window and clears the segment bits that fall past the window end.
//  Optionally bit-reverses the result per transaction. Streams one segment per cycle via valid/ready.
//  Also reports the surviving bit count to the downstream packer.
// PARAMETERS
//  SEG_W    15  segment width in bits (>=2)
//  POS_W    7   width of position input
//  WIN_LEN  61  window length; segment bit k sits at window index pos+k, valid while index < WIN_LEN
//  KEEP_W   $clog2(SEG_W+1)  width of kept-bit count (derived, do not override)
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        synchronous reset, active low
//  in_valid   in   1        input transaction valid
//  in_ready   out  1        unit can accept input this cycle
//  seg_in     in   SEG_W    segment data
//  pos_in     in   POS_W    window position of segment bit 0
//  rev_en     in   1        1: bit-reverse masked segment; 0: pass masked segment unreversed
//  out_valid  out  1        output transaction valid
//  out_ready  in   1        downstream accepts output
//  seg_out    out  SEG_W    masked (optionally reversed) segment
//  kept_out   out  KEEP_W   number of unmasked bits = SEG_W - overlap
//  busy       out  1        any pipeline stage holds a transaction
// BEHAVIOUR
//  - Reset: rst_n sampled low at a clk edge clears both stage valids. seg_out=0, kept_out=0,
//    out_valid=0 and busy=0 from that edge on. in_ready=1 while rst_n is low.
//  - Reset mid-operation: in-flight transactions are dropped, not completed.
//  - Handshake: input transfer on in_valid&&in_ready; output transfer on out_valid&&out_ready.
//    - Held inputs and outputs must stay stable while stalled (out_valid&&!out_ready).
//  - Ready chain, combinational from registered valids:
//    r2 = !v2 || out_ready; r1 = !v1 || r2; in_ready = r1.
//  - Stage 1, on load:
//    - sum = pos_in + SEG_W, computed in POS_W+2 bits (no overflow).
//    - ov = (sum > WIN_LEN) ? min(sum-WIN_LEN, SEG_W) : 0.
//    - Register masked = seg_in with bits [SEG_W-1 -: ov] forced 0; register kept = SEG_W-ov and rev_en.
//  - Stage 2, on load: seg_out = rev_en ? bitrev(masked) : masked (bitrev: out[i]=in[SEG_W-1-i]);
//    kept_out = kept.
//  - Latency: 2 cycles from input transfer to out_valid with no stall. Throughput 1 per cycle.
//    Full-rate streaming is possible while out_ready=1.
//  - Boundaries:
//    - pos_in <= WIN_LEN-SEG_W: no masking, kept=SEG_W.
//    - pos_in >= WIN_LEN: all bits cleared, kept=0.
//    - pos_in near 2^POS_W-1: clamp still applies, no wrap.
//  - Simultaneous events: output transfer and input transfer in the same cycle on a full pipe is
//    legal; both stages advance.
//  - Stalls: both stages full and out_ready=0 gives in_ready=0 and no register changes.
//  - busy = v1 || v2.
//  - seg_out and kept_out hold their last value when out_valid=0 (not cleared after transfer).
// STRUCTURE
//  - Package gng_mask_pkg:
//    - default SEG_W/WIN_LEN localparams.
//    - function calc_overlap(pos, seg_w, win_len) shared with the window-position tracker.
//  - Sub-module seg_bitrev #(W): purely combinational bit reverser, instantiated in stage 2.
//  - All other logic (two pipeline stages, ready chain) stays in this module.
// TESTING
//  1. seg_in=15'h7FFF, pos_in=50, rev_en=0 -> 2 cycles later seg_out=15'h07FF, kept_out=11.
//  2. seg_in=15'h7FFF, pos_in=50, rev_en=1 -> seg_out=15'h7FF0, kept_out=11.
//  3. seg_in=15'h0001, pos_in=10, rev_en=1 -> seg_out=15'h4000, kept_out=15.
//     Same input with pos_in=46 -> identical result (edge, no mask).
//  4. pos_in=61 and pos_in=127, seg_in=15'h7FFF -> seg_out=0, kept_out=0. pos_in=47 -> seg_out=15'h3FFF
//     (rev_en=0), kept_out=14.
//  5. Stream 8 back-to-back inputs with out_ready toggling 1,0,0,1,... -> no loss or duplication,
//    order preserved. in_ready=0 only when both stages are full and out_ready=0. Outputs stay stable
//    while stalled.
//  6. Pipe full, drive rst_n=0 for 1 cycle -> next edge out_valid=0, busy=0, seg_out=0, kept_out=0.
//    A fresh input after reset emerges alone after 2 cycles.

Source files
------------

// File: rtl/gng_mask_pkg.sv
// gng_mask_pkg
//   Shared definitions for the GNG segment-mask datapath.
//   - Default geometry of the segment/window (SEG_W_DEF, POS_W_DEF, WIN_LEN_DEF).
//   - calc_overlap(): how many high-order segment bits fall past the end of
//     the window. Also used by the window-position tracker, so it is kept
//     generic (plain integer arguments) rather than tied to one port width.
package gng_mask_pkg;

  localparam int SEG_W_DEF   = 15;
  localparam int POS_W_DEF   = 7;
  localparam int WIN_LEN_DEF = 61;

  // Segment bit k sits at window index pos+k and survives while that index is
  // below win_len. The overlap is the number of top bits past the end,
  // clamped to the segment width so far-out positions cannot over-count.
  function automatic int calc_overlap(input int pos, input int seg_w, input int win_len);
    int sum;
    sum = pos + seg_w;
    if (sum > win_len) begin
      return ((sum - win_len) < seg_w) ? (sum - win_len) : seg_w;
    end
    return 0;
  endfunction

endpackage

// File: rtl/seg_bitrev.sv
// seg_bitrev
//   Purely combinational bit reverser: dout[i] = din[W-1-i].
// Ports
//   din   in   W   input vector
//   dout  out  W   bit-reversed vector
module seg_bitrev #(
  parameter int W = 15
) (
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  for (genvar i = 0; i < W; i++) begin : g_rev
    assign dout[i] = din[W-1-i];
  end

endmodule

// File: rtl/seg_mask_pipe.sv
// seg_mask_pipe
//   Two-stage pipelined segment-mask unit. Clears the segment bits whose
//   window index (pos_in + k) lands at or past WIN_LEN, optionally bit-reverses
//   the masked segment, and reports how many bits survived.
// Ports
//   clk        in   1       rising-edge clock
//   rst_n      in   1       synchronous reset, active low
//   in_valid   in   1       input transaction valid
//   in_ready   out  1       unit can accept input this cycle
//   seg_in     in   SEG_W   segment data
//   pos_in     in   POS_W   window position of segment bit 0
//   rev_en     in   1       1: bit-reverse masked segment
//   out_valid  out  1       output transaction valid
//   out_ready  in   1       downstream accepts output
//   seg_out    out  SEG_W   masked (optionally reversed) segment
//   kept_out   out  KEEP_W  number of unmasked bits
//   busy       out  1       any pipeline stage holds a transaction
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. A producer holding valid keeps its data stable until the transfer;
// seg_out/kept_out stay stable while out_valid && !out_ready and keep their
// last value after the transfer. Ready flows backwards combinationally from
// the registered stage valids, so a full pipe can accept and emit in the same
// cycle.
module seg_mask_pipe
  import gng_mask_pkg::*;
#(
  parameter int SEG_W   = SEG_W_DEF,
  parameter int POS_W   = POS_W_DEF,
  parameter int WIN_LEN = WIN_LEN_DEF,
  parameter int KEEP_W  = $clog2(SEG_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEG_W-1:0]  seg_in,
  input  logic [POS_W-1:0]  pos_in,
  input  logic              rev_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SEG_W-1:0]  seg_out,
  output logic [KEEP_W-1:0] kept_out,
  output logic              busy
);

  // Stage 1 registers
  logic              v1;
  logic [SEG_W-1:0]  masked_q;
  logic [KEEP_W-1:0] kept_q;
  logic              rev_q;

  // Stage 2 valid (data lives directly in seg_out / kept_out)
  logic              v2;

  logic r1;
  logic r2;

  assign r2        = !v2 || out_ready;
  assign r1        = !v1 || r2;
  // While reset is held the unit is about to be emptied, so it advertises
  // ready regardless of what the stale valids say.
  assign in_ready  = !rst_n || r1;
  assign out_valid = v2;
  assign busy      = v1 || v2;

  // Stage 1 combinational mask
  int                ov_i;
  logic [KEEP_W-1:0] ov;
  logic [SEG_W-1:0]  keep_mask;
  logic [SEG_W-1:0]  masked_d;
  logic [KEEP_W-1:0] kept_d;

  always_comb begin
    ov_i      = calc_overlap(int'(pos_in), SEG_W, WIN_LEN);
    ov        = KEEP_W'(ov_i);
    // All-ones shifted right by ov leaves exactly the low SEG_W-ov bits set,
    // i.e. the top ov bits are the ones past the window end.
    keep_mask = {SEG_W{1'b1}} >> ov;
    masked_d  = seg_in & keep_mask;
    kept_d    = KEEP_W'(SEG_W) - ov;
  end

  // Stage 2 combinational reverse
  logic [SEG_W-1:0] rev_d;

  seg_bitrev #(.W(SEG_W)) u_bitrev (
    .din  (masked_q),
    .dout (rev_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      masked_q <= '0;
      kept_q   <= '0;
      rev_q    <= 1'b0;
      seg_out  <= '0;
      kept_out <= '0;
    end else begin
      if (r2) begin
        v2 <= v1;
        if (v1) begin
          seg_out  <= rev_q ? rev_d : masked_q;
          kept_out <= kept_q;
        end
      end
      if (r1) begin
        v1 <= in_valid;
        if (in_valid) begin
          masked_q <= masked_d;
          kept_q   <= kept_d;
          rev_q    <= rev_en;
        end
      end
    end
  end

endmodule
